// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared segment codes for the 7-segment display blocks.
// Bit order is {dp,g,f,e,d,c,b,a}, positive logic.
package seg7_scan_ctrl_pkg;

  localparam int SEG_BIT_DP = 7;

  localparam logic [7:0] SEG_0   = 8'h3F;
  localparam logic [7:0] SEG_1   = 8'h06;
  localparam logic [7:0] SEG_2   = 8'h5B;
  localparam logic [7:0] SEG_3   = 8'h4F;
  localparam logic [7:0] SEG_4   = 8'h66;
  localparam logic [7:0] SEG_5   = 8'h6D;
  localparam logic [7:0] SEG_6   = 8'h7D;
  localparam logic [7:0] SEG_7   = 8'h07;
  localparam logic [7:0] SEG_8   = 8'h7F;
  localparam logic [7:0] SEG_9   = 8'h6F;
  localparam logic [7:0] SEG_A   = 8'h77;
  localparam logic [7:0] SEG_B   = 8'h7C;
  localparam logic [7:0] SEG_C   = 8'h39;
  localparam logic [7:0] SEG_D   = 8'h5E;
  localparam logic [7:0] SEG_E   = 8'h79;
  localparam logic [7:0] SEG_F   = 8'h71;
  localparam logic [7:0] SEG_DP  = 8'h80;
  localparam logic [7:0] SEG_OFF = 8'h00;

endpackage

// File: rtl/seg7_scan_ctrl_decode.sv
// Hex nibble plus decimal point to positive-logic segment code.
// Purely combinational; shared by other display blocks.
module seg7_decode
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] glyph;

  always_comb begin
    glyph = SEG_OFF;
    unique case (nib)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = SEG_A;
      4'hB: glyph = SEG_B;
      4'hC: glyph = SEG_C;
      4'hD: glyph = SEG_D;
      4'hE: glyph = SEG_E;
      4'hF: glyph = SEG_F;
    endcase
    seg = glyph | (dp ? SEG_DP : SEG_OFF);
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner with dp, blank, blink,
// leading-zero blanking, PWM brightness and frame strobe.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int DIV_BITS   = 15,
  parameter int BLINK_BITS = 6,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic [4*DIGITS-1:0]   i_data,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic [DIGITS-1:0]     i_blank,
  input  logic [DIGITS-1:0]     i_blink,
  input  logic                  i_lzb,
  input  logic [3:0]            i_bright,
  output logic [7:0]            o_seg,
  output logic [DIGITS-1:0]     o_sel,
  output logic                  o_frame
);

  localparam int AW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0]        SEG_DARK = {8{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] SEL_DARK = {DIGITS{ACTIVE_LOW}};

  logic [DIV_BITS-1:0]   cnt;
  logic [AW-1:0]         addr;
  logic [BLINK_BITS-1:0] frm;
  logic                  tick;
  logic                  wrap;

  logic [4*DIGITS-1:0]   data_q;
  logic [DIGITS-1:0]     dp_q;
  logic [DIGITS-1:0]     blank_q;
  logic [DIGITS-1:0]     blink_q;
  logic                  lzb_q;
  logic [3:0]            bright_q;

  logic [DIGITS-1:0]     lz;
  logic                  any_nz;
  logic [3:0]            nib;
  logic                  dp_cur;
  logic                  blank_cur;
  logic                  blink_cur;
  logic                  lz_cur;
  logic                  pwm_off;
  logic                  dark;
  logic [7:0]            code;
  logic [DIGITS-1:0]     onehot;

  assign tick    = &cnt;
  assign wrap    = (addr == AW'(DIGITS - 1));
  assign o_frame = tick & wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      addr <= '0;
      frm  <= '0;
    end else begin
      cnt <= cnt + DIV_BITS'(1);
      if (tick)
        addr <= wrap ? '0 : addr + AW'(1);
      if (o_frame)
        frm <= frm + BLINK_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      dp_q     <= '0;
      blank_q  <= '0;
      blink_q  <= '0;
      lzb_q    <= 1'b0;
      bright_q <= '0;
    end else if (cs) begin
      data_q   <= i_data;
      dp_q     <= i_dp;
      blank_q  <= i_blank;
      blink_q  <= i_blink;
      lzb_q    <= i_lzb;
      bright_q <= i_bright;
    end
  end

  // Prefix-OR from the most significant digit down
  always_comb begin
    lz     = '0;
    any_nz = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      any_nz = any_nz | (|data_q[4*k +: 4]);
      lz[k]  = lzb_q & (k != 0) & ~any_nz;
    end
  end

  always_comb begin
    nib       = '0;
    dp_cur    = 1'b0;
    blank_cur = 1'b0;
    blink_cur = 1'b0;
    lz_cur    = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (addr == AW'(k)) begin
        nib       = data_q[4*k +: 4];
        dp_cur    = dp_q[k];
        blank_cur = blank_q[k];
        blink_cur = blink_q[k];
        lz_cur    = lz[k];
      end
    end
  end

  seg7_decode u_decode (
    .nib (nib),
    .dp  (dp_cur),
    .seg (code)
  );

  assign pwm_off = cnt[DIV_BITS-1 -: 4] > bright_q;
  assign dark    = blank_cur
                 | (blink_cur & frm[BLINK_BITS-1])
                 | pwm_off
                 | lz_cur;
  assign onehot  = DIGITS'(1) << addr;

  // Segments and select share one register so they never skew
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_seg <= SEG_DARK;
      o_sel <= SEL_DARK;
    end else if (dark) begin
      o_seg <= SEG_DARK;
      o_sel <= SEL_DARK;
    end else begin
      o_seg <= code ^ SEG_DARK;
      o_sel <= onehot ^ SEL_DARK;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: 8-digit active-low and 6-digit
// active-high instances against a cycle-count based model.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  dp = '0;
  logic [7:0]  blank = '0;
  logic [7:0]  blink = '0;
  logic        lzb = 1'b0;
  logic [3:0]  bright = '0;

  logic [7:0] seg8, sel8, seg6;
  logic [5:0] sel6;
  logic       frame8, frame6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .DIGITS(8), .DIV_BITS(4), .BLINK_BITS(2), .ACTIVE_LOW(1'b1)
  ) dut8 (
    .clk(clk), .rst(rst), .cs(cs), .i_data(data), .i_dp(dp),
    .i_blank(blank), .i_blink(blink), .i_lzb(lzb),
    .i_bright(bright), .o_seg(seg8), .o_sel(sel8),
    .o_frame(frame8)
  );

  seg7_scan_ctrl #(
    .DIGITS(6), .DIV_BITS(4), .BLINK_BITS(2), .ACTIVE_LOW(1'b0)
  ) dut6 (
    .clk(clk), .rst(rst), .cs(cs), .i_data(data[23:0]),
    .i_dp(dp[5:0]), .i_blank(blank[5:0]), .i_blink(blink[5:0]),
    .i_lzb(lzb), .i_bright(bright), .o_seg(seg6), .o_sel(sel6),
    .o_frame(frame6)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dp, blank, blink;
    logic        lzb;
    logic [3:0]  bright;
  } st_t;

  logic [7:0] tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F,
                           8'h66, 8'h6D, 8'h7D, 8'h07,
                           8'h7F, 8'h6F, 8'h77, 8'h7C,
                           8'h39, 8'h5E, 8'h79, 8'h71};

  // m = clk edges since reset release at the moment of sampling
  function automatic void model(input int m, input int nd,
                                input bit al, input st_t s,
                                output logic [7:0] seg,
                                output logic [7:0] sel);
    int slot, cnt, a, frm;
    longint upper;
    bit dk, lz;
    cnt  = m % 16;
    slot = m / 16;
    a    = slot % nd;
    frm  = (slot / nd) % 4;
    upper = (longint'(s.data) & ((64'd1 << (4 * nd)) - 1)) >> (4 * a);
    lz   = s.lzb && a != 0 && upper == 0;
    dk   = s.blank[a] || (s.blink[a] && frm >= 2)
        || (cnt > int'(s.bright)) || lz;
    if (dk) begin
      seg = 8'h00;
      sel = 8'h00;
    end else begin
      seg = tab[(s.data >> (4 * a)) & 32'hF] | (s.dp[a] ? 8'h80 : 8'h00);
      sel = 8'(1 << a);
    end
    if (al) begin
      seg = ~seg;
      sel = ~sel & 8'((1 << nd) - 1);
    end
  endfunction

  function automatic bit model_frame(input int m, input int nd);
    return (m % 16 == 15) && ((m / 16) % nd == nd - 1);
  endfunction

  st_t st;
  int  n = 0;
  logic [7:0] e_seg8 = 8'hFF, e_sel8 = 8'hFF;
  logic [7:0] e_seg6 = 8'h00, e_sel6 = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0;
      st = '{default: '0};
      e_seg8 = 8'hFF; e_sel8 = 8'hFF;
      e_seg6 = 8'h00; e_sel6 = 8'h00;
    end else begin
      model(n, 8, 1'b1, st, e_seg8, e_sel8);
      model(n, 6, 1'b0, st, e_seg6, e_sel6);
      if (cs) begin
        st.data = data; st.dp = dp; st.blank = blank;
        st.blink = blink; st.lzb = lzb; st.bright = bright;
      end
      n = n + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("seg8", 32'(seg8), 32'(e_seg8));
    chk("sel8", 32'(sel8), 32'(e_sel8));
    chk("seg6", 32'(seg6), 32'(e_seg6));
    chk("sel6", 32'(sel6), 32'(e_sel6[5:0]));
    chk("frame8", 32'(frame8), 32'(!rst && model_frame(n, 8)));
    chk("frame6", 32'(frame6), 32'(!rst && model_frame(n, 6)));
  end

  task automatic load(input logic [31:0] d, input logic [7:0] p,
                      input logic [7:0] bk, input logic [7:0] bl,
                      input logic lz, input logic [3:0] br);
    data = d; dp = p; blank = bk; blink = bl; lzb = lz; bright = br;
    cs = 1'b1;
    @(negedge clk);
    cs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_sel(input logic [7:0] target,
                          input logic [7:0] exp_seg,
                          input string name);
    bit found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (sel8 == target) found = 1;
    end
    if (!found) chk({name, "_timeout"}, 32'(sel8), 32'(target));
    else chk(name, 32'(seg8), 32'(exp_seg));
  endtask

  task automatic frame_period(input bit six, input int exp,
                              input string name);
    int t0 = -1, t1 = -1;
    for (int i = 0; i < 400 && t1 < 0; i++) begin
      @(negedge clk);
      if (six ? frame6 : frame8) begin
        if (t0 < 0) t0 = i;
        else t1 = i;
      end
    end
    chk(name, 32'(t1 - t0), 32'(exp));
  endtask

  task automatic count_lit(input int cycles, input string name,
                           input int exp);
    int lit = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (sel8 != 8'hFF) lit++;
    end
    chk(name, 32'(lit), 32'(exp));
  endtask

  logic [7:0] lit8 [8] = '{8'hA1, 8'hC6, 8'h83, 8'h88,
                           8'hB0, 8'hA4, 8'hF9, 8'hC0};

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(seg8), 32'hFF);
    chk("rst_sel", 32'(sel8), 32'hFF);
    rst = 1'b0;
    @(negedge clk);
    chk("first_seg", 32'(seg8), 32'hC0);
    chk("first_sel", 32'(sel8), 32'hFE);

    load(32'h0123ABCD, 8'h00, 8'h00, 8'h00, 1'b0, 4'd15);
    for (int k = 0; k < 8; k++)
      wait_sel(~(8'd1 << k), lit8[k], $sformatf("digit%0d", k));
    frame_period(1'b0, 128, "period8");
    frame_period(1'b1, 96, "period6");

    load(32'h00000050, 8'h00, 8'h00, 8'h00, 1'b1, 4'd15);
    wait_sel(8'hFD, 8'h92, "lzb_d1");
    wait_sel(8'hFE, 8'hC0, "lzb_d0");
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      if (sel8 != 8'hFF && sel8 != 8'hFE && sel8 != 8'hFD) bad++;
    end
    chk("lzb_dark", 32'(bad), 0);
    load(32'h0, 8'h00, 8'h00, 8'h00, 1'b1, 4'd15);
    count_lit(128, "lzb_zero_lit", 16);

    load(32'h0123ABCD, 8'h04, 8'h00, 8'h01, 1'b0, 4'd15);
    wait_sel(8'hFB, 8'h03, "dp_d2");
    count_lit(512, "blink_lit", 512 - 32);

    load(32'h0123ABCD, 8'h00, 8'h00, 8'h00, 1'b0, 4'd3);
    count_lit(128, "pwm3", 32);
    load(32'h0123ABCD, 8'h00, 8'h00, 8'h00, 1'b0, 4'd0);
    count_lit(128, "pwm0", 8);

    load(32'h0123ABCD, 8'h00, 8'h00, 8'h00, 1'b0, 4'd15);
    repeat (37) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_seg8", 32'(seg8), 32'hFF);
    chk("async_sel8", 32'(sel8), 32'hFF);
    chk("async_seg6", 32'(seg6), 32'h00);
    chk("async_sel6", 32'(sel6), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_sel8", 32'(sel8), 32'hFE);
    chk("restart_sel6", 32'(sel6), 32'h01);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0 || (cs && $urandom_range(0, 1) == 1)) begin
        cs = 1'b1;
        data = $urandom;
        if ($urandom_range(0, 3) == 0) data = data >> ($urandom_range(1, 7) * 4);
        dp = 8'($urandom); blank = 8'($urandom_range(0, 3) == 0 ? $urandom : 0);
        blink = 8'($urandom); lzb = 1'($urandom);
        bright = 4'($urandom_range(0, 3) == 0 ? $urandom : 15);
      end else begin
        cs = 1'b0;
      end
      @(negedge clk);
    end
    cs = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
